// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad front end.
//   kp_state_t : scan/debounce FSM states
//   KEYMAP     : hex value of each key, indexed [row][col]
//   COL_IDLE   : column drive after reset (column 0 active, active-low)
//   low_row    : index of the lowest-numbered low row in an active-low row vector
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  localparam logic [3:0] COL_IDLE = 4'b1110;

  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Scanning from the top index down leaves the lowest low index in idx.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RST_VAL into both stages
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
module sync_2ff #(
  parameter int                WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debounce.
//   new_clock      : system clock
//   nrst           : asynchronous active-low reset
//   row_d          : raw active-low row lines (asynchronous)
//   column_signals : active-low one-cold column drive
//   key_code       : hex code of the last accepted key, held until the next press
//   key_valid      : one-cycle strobe when key_code is updated
//   key_held       : high from the key_valid cycle until the release is accepted
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_TICKS = 50000
) (
  input  logic       new_clock,
  input  logic       nrst,
  input  logic [3:0] row_d,
  output logic [3:0] column_signals,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [3:0]       row_s;
  kp_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'b1111)) u_row_sync (
    .clk   (new_clock),
    .rst_n (nrst),
    .d     (row_d),
    .q     (row_s)
  );

  function automatic logic [3:0] next_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // One counter serves as the scan dwell timer in SCAN and the stability
  // count in DEBOUNCE/RELEASE; every state change clears it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    col_d       = col_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_s == 4'b1111) begin
            col_d = next_col(col_q);
          end else begin
            cand_d  = row_s;
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (row_s != cand_q) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = next_col(col_q);
        end else if (cnt_q == DEB_LAST) begin
          key_code_d  = KEYMAP[low_row(cand_q)][col_idx(col_q)];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (row_s == 4'b1111) state_d = RELEASE;
      end
      RELEASE: begin
        if (row_s != 4'b1111) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          key_held_d = 1'b0;
          state_d    = SCAN;
          cnt_d      = '0;
          col_d      = next_col(col_q);
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge new_clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      col_q       <= COL_IDLE;
      cand_q      <= 4'b1111;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign column_signals = col_q;
  assign key_code       = key_code_q;
  assign key_valid      = key_valid_q;
  assign key_held       = key_held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_TICKS=4, DEBOUNCE_TICKS=8.
// The keypad is modelled as a press mask: a pressed key pulls its row low
// only while its column is driven low.
module tb_keypad_scan_debounce;

  logic        clk;
  logic        nrst;
  logic [3:0]  row_d;
  logic [3:0]  column_signals;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] press;

  int errors;
  int checks;
  int strobes;
  logic [3:0] last_code;
  logic held_low_seen;
  logic held_bad;

  keypad_scan_debounce #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(8)) dut (
    .new_clock      (clk),
    .nrst           (nrst),
    .row_d          (row_d),
    .column_signals (column_signals),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .key_held       (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    row_d = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !column_signals[c]) row_d[r] = 1'b0;
      end
    end
  end

  // Advance n cycles, sampling on the falling edge and recording strobes.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) begin
        strobes++;
        last_code = key_code;
        if (!key_held) held_bad = 1'b1;
      end
      if (!key_held) held_low_seen = 1'b1;
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    checks++;
    if (column_signals !== 4'b1110) begin
      errors++; $display("FAIL %s_col: got %b want 1110", tag, column_signals);
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++; $display("FAIL %s_code: got %h want 0", tag, key_code);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL %s_valid: got %b want 0", tag, key_valid);
    end
    checks++;
    if (key_held !== 1'b0) begin
      errors++; $display("FAIL %s_held: got %b want 0", tag, key_held);
    end
  endtask

  task automatic test_reset;
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    nrst = 1'b0;
    press = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_reset("reset");
    nrst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_col = ~(one << (((i + 1) / 4) % 4));
      checks++;
      if (column_signals !== exp_col) begin
        errors++; $display("FAIL scan_col[%0d]: got %b want %b", i, column_signals, exp_col);
      end
      checks++;
      if (key_valid !== 1'b0) begin
        errors++; $display("FAIL scan_idle_valid[%0d]: got %b want 0", i, key_valid);
      end
    end
  endtask

  task automatic expect_press(input string tag, input logic [3:0] code, input logic [3:0] col);
    checks++;
    if (strobes !== 1) begin
      errors++; $display("FAIL %s_strobes: got %0d want 1", tag, strobes);
    end
    checks++;
    if (last_code !== code) begin
      errors++; $display("FAIL %s_code: got %h want %h", tag, last_code, code);
    end
    checks++;
    if (key_held !== 1'b1) begin
      errors++; $display("FAIL %s_held: got %b want 1", tag, key_held);
    end
    checks++;
    if (held_bad !== 1'b0) begin
      errors++; $display("FAIL %s_held_with_valid: got %b want 0", tag, held_bad);
    end
    checks++;
    if (column_signals !== col) begin
      errors++; $display("FAIL %s_frozen_col: got %b want %b", tag, column_signals, col);
    end
  endtask

  task automatic expect_released(input string tag, input logic [3:0] code);
    checks++;
    if (key_held !== 1'b0) begin
      errors++; $display("FAIL %s_rel_held: got %b want 0", tag, key_held);
    end
    checks++;
    if (strobes !== 1) begin
      errors++; $display("FAIL %s_rel_strobes: got %0d want 1", tag, strobes);
    end
    checks++;
    if (key_code !== code) begin
      errors++; $display("FAIL %s_rel_code: got %h want %h", tag, key_code, code);
    end
  endtask

  task automatic test_single_press;
    strobes = 0; held_bad = 1'b0;
    press[0] = 1'b1;
    run(40);
    expect_press("r0c0", 4'h1, 4'b1110);
    press[0] = 1'b0;
    run(30);
    expect_released("r0c0", 4'h1);
  endtask

  task automatic test_press_bounce;
    strobes = 0; held_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      press[13] = 1'b1;
      run(3);
      press[13] = 1'b0;
      run(3);
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL bounce_strobes: got %0d want 0", strobes);
    end
    press[13] = 1'b1;
    run(40);
    expect_press("r3c1", 4'h0, 4'b1101);
    press[13] = 1'b0;
    run(30);
    expect_released("r3c1", 4'h0);
  endtask

  task automatic test_second_key_ignored;
    strobes = 0; held_bad = 1'b0;
    press[6] = 1'b1;
    run(40);
    expect_press("r1c2", 4'h6, 4'b1011);
    press[8] = 1'b1;
    run(30);
    expect_press("r1c2_r2c0", 4'h6, 4'b1011);
    checks++;
    if (key_code !== 4'h6) begin
      errors++; $display("FAIL two_key_code: got %h want 6", key_code);
    end
    press[6] = 1'b0;
    press[8] = 1'b0;
    run(30);
    expect_released("two_key", 4'h6);
  endtask

  task automatic test_release_bounce;
    strobes = 0; held_bad = 1'b0;
    press[1] = 1'b1;
    run(40);
    expect_press("r0c1", 4'h2, 4'b1101);
    held_low_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      press[1] = 1'b0;
      run(3);
      press[1] = 1'b1;
      run(3);
    end
    checks++;
    if (held_low_seen !== 1'b0) begin
      errors++; $display("FAIL rel_bounce_held_dropped: got %b want 0", held_low_seen);
    end
    checks++;
    if (strobes !== 1) begin
      errors++; $display("FAIL rel_bounce_strobes: got %0d want 1", strobes);
    end
    press[1] = 1'b0;
    run(30);
    expect_released("r0c1", 4'h2);
  endtask

  task automatic test_reset_in_debounce;
    int waited;
    strobes = 0;
    waited = 0;
    while (column_signals !== 4'b1011 && waited < 40) begin
      run(1);
      waited++;
    end
    press[11] = 1'b1;
    waited = 0;
    while (column_signals !== 4'b0111 && waited < 40) begin
      run(1);
      waited++;
    end
    checks++;
    if (column_signals !== 4'b0111) begin
      errors++; $display("FAIL wait_col3: got %b want 0111", column_signals);
    end
    run(5);
    checks++;
    if (column_signals !== 4'b0111) begin
      errors++; $display("FAIL debounce_frozen_col: got %b want 0111", column_signals);
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL debounce_early_strobe: got %0d want 0", strobes);
    end
    nrst = 1'b0;
    press = '0;
    #1;
    check_outputs_reset("midreset");
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    strobes = 0;
    run(60);
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL post_reset_strobes: got %0d want 0", strobes);
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++; $display("FAIL post_reset_code: got %h want 0", key_code);
    end
    checks++;
    if (key_held !== 1'b0) begin
      errors++; $display("FAIL post_reset_held: got %b want 0", key_held);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    strobes = 0;
    last_code = 4'h0;
    held_low_seen = 1'b0;
    held_bad = 1'b0;
    nrst = 1'b0;
    press = '0;
    test_reset();
    test_single_press();
    test_press_bounce();
    test_second_key_ignored();
    test_release_bounce();
    test_reset_in_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
